// File: rtl/perf_monitor_pkg.sv
// Shared types and constants for the pipeline performance monitor.
package perf_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SEL_CYCLE    = 0;
    localparam int SEL_EVT_BASE = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating counter with sticky overflow flag. cnt_next_o is the value the
// counter takes at the coming edge, so snapshots can include this cycle's increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_next_o,
    output logic         ovf_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_next_o = cnt_d;
    assign ovf_o      = ovf_q;

endmodule

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: run-cycle and event counters, run-limit FSM,
// atomic snapshot shadow bank and registered select readout.
module perf_monitor
    import perf_monitor_pkg::*;
#(
    parameter int NUM_EVENTS  = 4,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 64,
    localparam int SEL_W      = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  snap_i,
    input  logic [SEL_W-1:0]      rd_sel_i,
    output logic [CNT_W-1:0]      rd_data_o,
    output logic                  snap_valid_o,
    output logic [NUM_EVENTS:0]   ovf_o,
    output logic                  running_o,
    output logic                  done_o
);

    localparam int NCH = NUM_EVENTS + 1;

    state_e                     state_q, state_d;
    logic                       counting;
    logic [NCH-1:0]             inc;
    logic [NCH-1:0][CNT_W-1:0]  cnt_nx;
    logic [NCH-1:0][CNT_W-1:0]  shadow_q, shadow_d;
    logic                       snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0]           rd_q, rd_d;

    assign counting = (state_q == RUN) && start_i;

    always_comb begin
        inc            = '0;
        inc[SEL_CYCLE] = counting;
        for (int k = 0; k < NUM_EVENTS; k++)
            inc[SEL_EVT_BASE + k] = counting & event_i[k];
    end

    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clr_i      (clear_i),
            .inc_i      (inc[g]),
            .cnt_next_o (cnt_nx[g]),
            .ovf_o      (ovf_o[g])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i) state_d = RUN;
            RUN: begin
                if (!start_i)
                    state_d = IDLE;
                else if (CYCLE_LIMIT != 0 && cnt_nx[SEL_CYCLE] == CNT_W'(CYCLE_LIMIT))
                    state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    // Shadows take the post-edge counter values so this cycle's increments land in the snapshot.
    always_comb begin
        shadow_d     = shadow_q;
        snap_valid_d = snap_valid_q;
        if (clear_i) begin
            shadow_d     = '0;
            snap_valid_d = 1'b0;
        end else if (snap_i) begin
            shadow_d     = cnt_nx;
            snap_valid_d = 1'b1;
        end
    end

    always_comb begin
        rd_d = '0;
        if (int'(rd_sel_i) < NCH) rd_d = shadow_q[rd_sel_i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            snap_valid_q <= 1'b0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            snap_valid_q <= snap_valid_d;
            rd_q         <= rd_d;
        end
    end

    assign rd_data_o    = rd_q;
    assign snap_valid_o = snap_valid_q;
    assign running_o    = (state_q == RUN);
    assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: two configurations driven in lockstep and compared
// every cycle against a behavioural model, plus hand-computed spot checks.
module tb_perf_monitor;

    localparam int NE = 4;
    localparam int SW = $clog2(NE + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, clear, snap;
    logic [NE-1:0] ev;
    logic [SW-1:0] sel;
    logic [31:0]   rd0;
    logic [3:0]    rd1;
    logic          sv0, sv1, run0, run1, dn0, dn1;
    logic [NE:0]   ovf0, ovf1;

    perf_monitor #(.NUM_EVENTS(NE), .CNT_W(32), .CYCLE_LIMIT(64)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
        .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rd0), .snap_valid_o(sv0),
        .ovf_o(ovf0), .running_o(run0), .done_o(dn0));

    perf_monitor #(.NUM_EVENTS(NE), .CNT_W(4), .CYCLE_LIMIT(0)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
        .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rd1), .snap_valid_o(sv1),
        .ovf_o(ovf1), .running_o(run1), .done_o(dn1));

    // Model: mode flags, counts, shadows, sticky flags per instance.
    longint m_max[2] = '{64'hFFFF_FFFF, 64'd15};
    longint m_lim[2] = '{64'd64, 64'd0};
    longint m_cnt[2][NE+1];
    longint m_sh[2][NE+1];
    bit     m_ovf[2][NE+1];
    bit     m_run[2], m_done[2], m_sv[2];
    longint m_rd[2];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [NE:0] ovec(int i);
        logic [NE:0] r;
        for (int c = 0; c <= NE; c++) r[c] = m_ovf[i][c];
        return r;
    endfunction

    task automatic model_step(int i);
        bit cnting, hit;
        if (int'(sel) <= NE) m_rd[i] = m_sh[i][int'(sel)];
        else                 m_rd[i] = 0;
        if (rst) begin
            for (int c = 0; c <= NE; c++) begin
                m_cnt[i][c] = 0; m_sh[i][c] = 0; m_ovf[i][c] = 0;
            end
            m_run[i] = 0; m_done[i] = 0; m_sv[i] = 0; m_rd[i] = 0;
            return;
        end
        if (clear) begin
            for (int c = 0; c <= NE; c++) begin
                m_cnt[i][c] = 0; m_sh[i][c] = 0; m_ovf[i][c] = 0;
            end
            m_run[i] = 0; m_done[i] = 0; m_sv[i] = 0;
            return;
        end
        cnting = m_run[i] && start;
        if (cnting) begin
            for (int c = 0; c <= NE; c++) begin
                hit = (c == 0) ? 1'b1 : ev[c-1];
                if (hit) begin
                    if (m_cnt[i][c] == m_max[i]) m_ovf[i][c] = 1;
                    else                         m_cnt[i][c]++;
                end
            end
        end
        if (m_done[i]) begin
        end else if (!m_run[i] && start) begin
            m_run[i] = 1;
        end else if (m_run[i] && !start) begin
            m_run[i] = 0;
        end else if (m_run[i] && m_lim[i] != 0 && m_cnt[i][0] == m_lim[i]) begin
            m_run[i] = 0; m_done[i] = 1;
        end
        if (snap) begin
            for (int c = 0; c <= NE; c++) m_sh[i][c] = m_cnt[i][c];
            m_sv[i] = 1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd0",   64'(rd0),  64'(m_rd[0]));
            check("sv0",   64'(sv0),  64'(m_sv[0]));
            check("ovf0",  64'(ovf0), 64'(ovec(0)));
            check("run0",  64'(run0), 64'(m_run[0]));
            check("done0", 64'(dn0),  64'(m_done[0]));
            check("rd1",   64'(rd1),  64'(m_rd[1]));
            check("sv1",   64'(sv1),  64'(m_sv[1]));
            check("ovf1",  64'(ovf1), 64'(ovec(1)));
            check("run1",  64'(run1), 64'(m_run[1]));
            check("done1", 64'(dn1),  64'(m_done[1]));
        end
    end

    // Advance n rising edges; returns just after the following falling edge.
    task automatic step(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic all_zero(string tag);
        check({tag, "_rd0"},  64'(rd0),  64'd0);
        check({tag, "_sv0"},  64'(sv0),  64'd0);
        check({tag, "_ovf0"}, 64'(ovf0), 64'd0);
        check({tag, "_run0"}, 64'(run0), 64'd0);
        check({tag, "_dn0"},  64'(dn0),  64'd0);
        check({tag, "_rd1"},  64'(rd1),  64'd0);
        check({tag, "_ovf1"}, 64'(ovf1), 64'd0);
        check({tag, "_run1"}, 64'(run1), 64'd0);
    endtask

    int exp_t1[5] = '{64, 32, 64, 0, 0};

    initial begin
        rst = 1; start = 0; clear = 0; snap = 0; ev = '0; sel = '0;
        @(negedge clk); #1;
        chk_en = 1;
        step(1);
        all_zero("reset");
        rst = 0;

        // Limit run: event 0 toggles, event 1 always high.
        start = 1;
        for (int c = 0; c < 70; c++) begin
            ev = 4'b0010 | 4'((c % 2) == 0);
            step(1);
        end
        check("t1_done0", 64'(dn0), 64'd1);
        check("t1_run0",  64'(run0), 64'd0);
        snap = 1; sel = 0; step(1); snap = 0;
        for (int s = 0; s <= NE; s++) begin
            sel = SW'(s); step(1);
            check($sformatf("t1_sel%0d", s), 64'(rd0), 64'(exp_t1[s]));
            if (s == 0) check("t2_cyc_sat", 64'(rd1), 64'd15);
            if (s == 1) check("t2_ev0_sat", 64'(rd1), 64'd15);
        end
        check("t2_ovf_low", 64'(ovf1[1:0]), 64'd3);

        // Pause test.
        start = 0; clear = 1; ev = '1; step(1); clear = 0;
        start = 1; step(11);
        start = 0; step(2);
        check("pause_run0", 64'(run0), 64'd0);
        step(3);
        check("pause_run0_end", 64'(run0), 64'd0);
        start = 1; step(11);
        start = 0; snap = 1; sel = 0; step(1); snap = 0;
        for (int s = 0; s <= NE; s++) begin
            sel = SW'(s); step(1);
            check($sformatf("pause_sel%0d", s), 64'(rd0), 64'd20);
        end

        // Clear and snap on the same edge after 30 counts.
        clear = 1; step(1); clear = 0;
        start = 1; step(31);
        snap = 1; clear = 1; start = 0; step(1); snap = 0; clear = 0;
        check("cs_sv0",  64'(sv0),  64'd0);
        check("cs_run0", 64'(run0), 64'd0);
        check("cs_dn0",  64'(dn0),  64'd0);
        sel = 0; step(1);
        check("cs_sel0", 64'(rd0), 64'd0);
        sel = 2; step(1);
        check("cs_sel2", 64'(rd0), 64'd0);

        // Out-of-range select.
        start = 1; ev = 4'b0101; step(5);
        snap = 1; step(1); snap = 0;
        sel = 0; step(1);
        check("oor_sel0", 64'(rd0), 64'd5);
        sel = 5; step(1);
        check("oor_sel5", 64'(rd0), 64'd0);
        sel = 1; step(1);
        check("oor_sel1", 64'(rd0), 64'd5);
        sel = 7; step(1);
        check("oor_sel7", 64'(rd0), 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            clear = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 7) != 0);
            snap  = ($urandom_range(0, 5) == 0);
            ev    = NE'($urandom);
            sel   = SW'($urandom_range(0, 7));
            step(1);
        end

        // Reset mid-run.
        rst = 0; snap = 0; clear = 1; step(1); clear = 0;
        start = 1; ev = '1; step(10);
        snap = 1; step(1); snap = 0; sel = 1; step(1);
        check("mid_run0", 64'(run0), 64'd1);
        check("mid_rd0",  64'(rd0),  64'd10);
        rst = 1; step(1);
        all_zero("midrst");
        rst = 0; start = 0; step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
